// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_pkg
// Description : Mode encoding, per-mode timing record and the constant
//               timing table shared by the video timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
package video_timing_pkg;

  localparam int TIM_HW = 12;  // width of horizontal timing fields
  localparam int TIM_VW = 11;  // width of vertical timing fields

  typedef enum logic [1:0] {
    MODE_480P    = 2'd0,
    MODE_720P    = 2'd1,
    MODE_1080P   = 2'd2,
    MODE_INVALID = 2'd3
  } mode_e;

  // Active / front porch / sync / back porch for both axes plus polarity.
  typedef struct packed {
    logic [TIM_HW-1:0] h_act;
    logic [TIM_HW-1:0] h_fp;
    logic [TIM_HW-1:0] h_sync;
    logic [TIM_HW-1:0] h_bp;
    logic [TIM_VW-1:0] v_act;
    logic [TIM_VW-1:0] v_fp;
    logic [TIM_VW-1:0] v_sync;
    logic [TIM_VW-1:0] v_bp;
    logic              sync_pos;  // 1: sync pulses high, 0: sync pulses low
  } timing_t;

  localparam timing_t TIMING_480P = '{
    h_act: 12'd640,  h_fp: 12'd16,  h_sync: 12'd96, h_bp: 12'd48,
    v_act: 11'd480,  v_fp: 11'd10,  v_sync: 11'd2,  v_bp: 11'd33,
    sync_pos: 1'b0
  };

  localparam timing_t TIMING_720P = '{
    h_act: 12'd1280, h_fp: 12'd110, h_sync: 12'd40, h_bp: 12'd220,
    v_act: 11'd720,  v_fp: 11'd5,   v_sync: 11'd5,  v_bp: 11'd20,
    sync_pos: 1'b1
  };

  localparam timing_t TIMING_1080P = '{
    h_act: 12'd1920, h_fp: 12'd88,  h_sync: 12'd44, h_bp: 12'd148,
    v_act: 11'd1080, v_fp: 11'd4,   v_sync: 11'd5,  v_bp: 11'd36,
    sync_pos: 1'b1
  };

  // Indexed by mode value; entry 0 is 480p.
  localparam timing_t [2:0] TIMING_TABLE = {TIMING_1080P, TIMING_720P, TIMING_480P};

  function automatic logic [TIM_HW-1:0] h_total(input timing_t t);
    return t.h_act + t.h_fp + t.h_sync + t.h_bp;
  endfunction

  function automatic logic [TIM_VW-1:0] v_total(input timing_t t);
    return t.v_act + t.v_fp + t.v_sync + t.v_bp;
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_mode_rom.sv
`default_nettype none
// ============================================================================
// Module      : video_mode_rom
// Description : Combinational lookup from mode code to timing record.
// Revision    : 1.0 - initial release
// ============================================================================
module video_mode_rom
  import video_timing_pkg::*;
(
  input  logic [1:0] mode_i,
  output timing_t    timing_o
);

  // The invalid code never reaches the running mode; map it to 720p anyway
  // so the lookup is total.
  always_comb begin
    timing_o = TIMING_TABLE[1];
    case (mode_i)
      MODE_480P:  timing_o = TIMING_TABLE[0];
      MODE_720P:  timing_o = TIMING_TABLE[1];
      MODE_1080P: timing_o = TIMING_TABLE[2];
      default:    timing_o = TIMING_TABLE[1];
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Raster counter and sync/active/new-frame decoder for
//               480p/720p/1080p with mode switching aligned to frame wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_WIDTH      = 12,
  parameter int V_WIDTH      = 11,
  parameter int FC_MAX       = 59,
  parameter int DEFAULT_MODE = 1
) (
  input  logic               clk_pixel_in,
  input  logic               rst_n_in,
  input  logic [1:0]         mode_in,
  input  logic               mode_req_in,
  output logic               mode_ack_out,
  output logic               mode_err_out,
  output logic [1:0]         mode_out,
  output logic [H_WIDTH-1:0] hcount_out,
  output logic [V_WIDTH-1:0] vcount_out,
  output logic               hs_out,
  output logic               vs_out,
  output logic               ad_out,
  output logic               nf_out,
  output logic [5:0]         fc_out
);

  localparam mode_e RESET_MODE = mode_e'(2'(DEFAULT_MODE));

  logic [H_WIDTH-1:0] hcount_q, hcount_d;
  logic [V_WIDTH-1:0] vcount_q, vcount_d;
  logic [5:0]         fc_q, fc_d;
  mode_e              mode_q, mode_d;
  mode_e              pend_mode_q, pend_mode_d;
  logic               pend_valid_q, pend_valid_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  timing_t            w_tim;
  logic [H_WIDTH-1:0] w_h_act, w_hs_start, w_hs_stop, w_h_last;
  logic [V_WIDTH-1:0] w_v_act, w_vs_start, w_vs_stop, w_v_last;
  logic               w_h_wrap, w_frame_wrap, w_nf;
  logic               w_hs_act, w_vs_act;
  logic               w_req_ok, w_req_bad;

  // Timing of the mode currently being generated.
  video_mode_rom u_mode_rom (
    .mode_i   (mode_q),
    .timing_o (w_tim)
  );

  // Region boundaries, all relative to the start of the active area.
  assign w_h_act    = H_WIDTH'(w_tim.h_act);
  assign w_hs_start = H_WIDTH'(w_tim.h_act + w_tim.h_fp);
  assign w_hs_stop  = H_WIDTH'(w_tim.h_act + w_tim.h_fp + w_tim.h_sync);
  assign w_h_last   = H_WIDTH'(h_total(w_tim) - TIM_HW'(1));
  assign w_v_act    = V_WIDTH'(w_tim.v_act);
  assign w_vs_start = V_WIDTH'(w_tim.v_act + w_tim.v_fp);
  assign w_vs_stop  = V_WIDTH'(w_tim.v_act + w_tim.v_fp + w_tim.v_sync);
  assign w_v_last   = V_WIDTH'(v_total(w_tim) - TIM_VW'(1));

  assign w_h_wrap     = (hcount_q == w_h_last);
  assign w_frame_wrap = w_h_wrap && (vcount_q == w_v_last);
  assign w_nf         = (hcount_q == w_h_act) && (vcount_q == w_v_act);
  assign w_hs_act     = (hcount_q >= w_hs_start) && (hcount_q < w_hs_stop);
  assign w_vs_act     = (vcount_q >= w_vs_start) && (vcount_q < w_vs_stop);
  assign w_req_ok     = mode_req_in && (mode_in != MODE_INVALID);
  assign w_req_bad    = mode_req_in && (mode_in == MODE_INVALID);

  // Next-state: raster advance, frame counter, and mode request handling.
  always_comb begin
    hcount_d     = hcount_q + H_WIDTH'(1);
    vcount_d     = vcount_q;
    fc_d         = fc_q;
    mode_d       = mode_q;
    pend_mode_d  = pend_mode_q;
    pend_valid_d = pend_valid_q;
    ack_d        = 1'b0;
    err_d        = w_req_bad;

    if (w_h_wrap) begin
      hcount_d = '0;
      vcount_d = w_frame_wrap ? '0 : vcount_q + V_WIDTH'(1);
    end

    if (w_nf) begin
      fc_d = (fc_q == 6'(FC_MAX)) ? '0 : fc_q + 6'd1;
    end

    // A request arriving on the wrap cycle itself is newer than anything
    // pending, so it takes priority and is applied at this same wrap.
    if (w_frame_wrap) begin
      if (w_req_ok) begin
        mode_d       = mode_e'(mode_in);
        pend_valid_d = 1'b0;
        ack_d        = 1'b1;
      end else if (pend_valid_q) begin
        mode_d       = pend_mode_q;
        pend_valid_d = 1'b0;
        ack_d        = 1'b1;
      end
    end else if (w_req_ok) begin
      pend_mode_d  = mode_e'(mode_in);
      pend_valid_d = 1'b1;
    end
  end

  // State register; reset discards counters, pending request and pulses.
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      fc_q         <= '0;
      mode_q       <= RESET_MODE;
      pend_mode_q  <= RESET_MODE;
      pend_valid_q <= 1'b0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      fc_q         <= fc_d;
      mode_q       <= mode_d;
      pend_mode_q  <= pend_mode_d;
      pend_valid_q <= pend_valid_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
    end
  end

  assign hcount_out   = hcount_q;
  assign vcount_out   = vcount_q;
  assign fc_out       = fc_q;
  assign mode_out     = mode_q;
  assign mode_ack_out = ack_q;
  assign mode_err_out = err_q;
  assign nf_out       = w_nf;
  assign ad_out       = (hcount_q < w_h_act) && (vcount_q < w_v_act);
  assign hs_out       = w_tim.sync_pos ? w_hs_act : ~w_hs_act;
  assign vs_out       = w_tim.sync_pos ? w_vs_act : ~w_vs_act;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_timing_gen
// Description : Self-checking bench for video_timing_gen: per-cycle
//               scoreboard against a frame model, decode vector table and
//               hand-written mode-switch / reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_timing_gen;

  typedef struct packed {
    logic [11:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;
    logic [1:0]  mode;
    logic        ack;
    logic        err;
  } obs_t;

  typedef struct packed {
    int unsigned hact, hfp, hsy, hbp, vact, vfp, vsy, vbp;
    logic        pos;
  } tim_t;

  // One decode vector: position to jump to and expected {hs,vs,ad,nf}.
  typedef struct {
    logic [1:0] mode;
    int         h;
    int         v;
    logic [3:0] exp;
  } dec_vec_t;

  localparam obs_t RST_OBS = '{12'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0, 2'd1, 1'b0, 1'b0};

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode_i;
  logic        mode_req;
  logic        ack, err, hs, vs, ad, nf;
  logic [1:0]  mode_o;
  logic [11:0] hcount;
  logic [10:0] vcount;
  logic [5:0]  fc;

  video_timing_gen #(
    .H_WIDTH(12), .V_WIDTH(11), .FC_MAX(59), .DEFAULT_MODE(1)
  ) dut (
    .clk_pixel_in (clk),
    .rst_n_in     (rst_n),
    .mode_in      (mode_i),
    .mode_req_in  (mode_req),
    .mode_ack_out (ack),
    .mode_err_out (err),
    .mode_out     (mode_o),
    .hcount_out   (hcount),
    .vcount_out   (vcount),
    .hs_out       (hs),
    .vs_out       (vs),
    .ad_out       (ad),
    .nf_out       (nf),
    .fc_out       (fc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1);
  end

  // Reference model state (value of DUT registers after the last edge).
  int unsigned m_h, m_v, m_fc;
  logic [1:0]  m_mode, m_pm;
  logic        m_pv, m_ack, m_err;

  obs_t        exp_q[$];
  obs_t        cur;
  dec_vec_t    vecs[$];
  int          total, bad;
  logic [11:0] jmp_h;
  logic [10:0] jmp_v;

  function automatic tim_t tim_of(input logic [1:0] m);
    case (m)
      2'd0:    return '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
      2'd2:    return '{1920, 88, 44, 148, 1080, 4, 5, 36, 1'b1};
      default: return '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1};
    endcase
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = '{hcount, vcount, hs, vs, ad, nf, fc, mode_o, ack, err};
    return o;
  endfunction

  function automatic obs_t model_obs();
    tim_t t;
    obs_t o;
    logic hsa, vsa;
    t    = tim_of(m_mode);
    hsa  = (m_h >= t.hact + t.hfp) && (m_h < t.hact + t.hfp + t.hsy);
    vsa  = (m_v >= t.vact + t.vfp) && (m_v < t.vact + t.vfp + t.vsy);
    o.h  = 12'(m_h);
    o.v  = 11'(m_v);
    o.hs = t.pos ? hsa : !hsa;
    o.vs = t.pos ? vsa : !vsa;
    o.ad = (m_h < t.hact) && (m_v < t.vact);
    o.nf = (m_h == t.hact) && (m_v == t.vact);
    o.fc = 6'(m_fc);
    o.mode = m_mode;
    o.ack = m_ack;
    o.err = m_err;
    return o;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_fc = 0; m_mode = 2'd1; m_pm = 2'd1;
    m_pv = 1'b0; m_ack = 1'b0; m_err = 1'b0;
  endtask

  // Advance the model by one clock given the inputs sampled at that edge.
  task automatic model_step(input logic req, input logic [1:0] mi);
    tim_t        t;
    int unsigned htot, vtot;
    logic        ok;
    t    = tim_of(m_mode);
    htot = t.hact + t.hfp + t.hsy + t.hbp;
    vtot = t.vact + t.vfp + t.vsy + t.vbp;
    ok   = req && (mi != 2'd3);
    if (m_h == t.hact && m_v == t.vact) m_fc = (m_fc == 59) ? 0 : m_fc + 1;
    m_err = req && (mi == 2'd3);
    m_ack = 1'b0;
    if (m_h == htot - 1 && m_v == vtot - 1) begin
      m_h = 0;
      m_v = 0;
      if (ok) begin
        m_mode = mi; m_pv = 1'b0; m_ack = 1'b1;
      end else if (m_pv) begin
        m_mode = m_pm; m_pv = 1'b0; m_ack = 1'b1;
      end
    end else begin
      if (ok) begin
        m_pv = 1'b1; m_pm = mi;
      end
      if (m_h == htot - 1) begin
        m_h = 0; m_v = m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
    end
  endtask

  task automatic check_obs(input string name, input obs_t act, input obs_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: drive at negedge, queue the model's prediction, compare after
  // the rising edge.
  task automatic tick(input logic req, input logic [1:0] mi);
    @(negedge clk);
    mode_req = req;
    mode_i   = mi;
    model_step(req, mi);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    cur = dut_obs();
    check_obs("cycle", cur, exp_q.pop_front());
  endtask

  // Move the raster to (h,v) between edges so distant positions are reachable.
  task automatic jump(input int unsigned h, input int unsigned v);
    jmp_h = 12'(h);
    jmp_v = 11'(v);
    force dut.hcount_q = jmp_h;
    force dut.vcount_q = jmp_v;
    #1;
    release dut.hcount_q;
    release dut.vcount_q;
    #1;
    m_h = h;
    m_v = v;
  endtask

  task automatic assert_reset();
    mode_req = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    check_obs("reset_state", dut_obs(), RST_OBS);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_obs("reset_hold", dut_obs(), RST_OBS);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_step(1'b0, 2'd0);
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    cur = dut_obs();
    check_obs("reset_release", cur, exp_q.pop_front());
  endtask

  task automatic add_vec(input logic [1:0] m, input int h, input int v, input logic [3:0] e);
    dec_vec_t d;
    d.mode = m; d.h = h; d.v = v; d.exp = e;
    vecs.push_back(d);
  endtask

  task automatic run_table(input logic [1:0] m);
    foreach (vecs[i]) begin
      if (vecs[i].mode == m) begin
        jump(vecs[i].h, vecs[i].v);
        check_val($sformatf("decode_m%0d_h%0d_v%0d", m, vecs[i].h, vecs[i].v),
                  int'({hs, vs, ad, nf}), int'(vecs[i].exp));
        tick(1'b0, 2'd0);
      end
    end
  endtask

  task automatic run_count(input int n, output int acks);
    acks = 0;
    repeat (n) begin
      tick(1'b0, 2'd0);
      if (cur.ack) acks++;
    end
  endtask

  int nf_cnt, nf_h, nf_v, first_pos, last_pos, acks;

  initial begin
    // {hs,vs,ad,nf} at chosen positions of each mode
    add_vec(2'd1, 0, 0, 4'b0010);       add_vec(2'd1, 1279, 719, 4'b0010);
    add_vec(2'd1, 1280, 719, 4'b0000);  add_vec(2'd1, 1279, 720, 4'b0000);
    add_vec(2'd1, 1280, 720, 4'b0001);  add_vec(2'd1, 1389, 10, 4'b0000);
    add_vec(2'd1, 1390, 10, 4'b1000);   add_vec(2'd1, 1429, 10, 4'b1000);
    add_vec(2'd1, 1430, 10, 4'b0000);   add_vec(2'd1, 0, 724, 4'b0000);
    add_vec(2'd1, 0, 725, 4'b0100);     add_vec(2'd1, 0, 729, 4'b0100);
    add_vec(2'd1, 0, 730, 4'b0000);
    add_vec(2'd0, 0, 0, 4'b1110);       add_vec(2'd0, 639, 479, 4'b1110);
    add_vec(2'd0, 655, 0, 4'b1100);     add_vec(2'd0, 656, 0, 4'b0100);
    add_vec(2'd0, 751, 0, 4'b0100);     add_vec(2'd0, 752, 0, 4'b1100);
    add_vec(2'd0, 0, 489, 4'b1100);     add_vec(2'd0, 0, 490, 4'b1000);
    add_vec(2'd0, 0, 491, 4'b1000);     add_vec(2'd0, 0, 492, 4'b1100);
    add_vec(2'd0, 640, 480, 4'b1101);
    add_vec(2'd2, 2007, 0, 4'b0000);    add_vec(2'd2, 2008, 0, 4'b1000);
    add_vec(2'd2, 2051, 0, 4'b1000);    add_vec(2'd2, 2052, 0, 4'b0000);
    add_vec(2'd2, 0, 1084, 4'b0100);    add_vec(2'd2, 0, 1088, 4'b0100);
    add_vec(2'd2, 0, 1089, 4'b0000);    add_vec(2'd2, 1919, 1079, 4'b0010);
    add_vec(2'd2, 1920, 1080, 4'b0001);

    total = 0; bad = 0;
    rst_n = 1'b1; mode_req = 1'b0; mode_i = 2'd0;
    model_reset();
    #2;
    assert_reset();

    // 720p: one new-frame pulse at (1280,720), hsync 1390..1429, fc -> 1
    jump(1270, 720);
    nf_cnt = 0; nf_h = -1; nf_v = -1; first_pos = -1; last_pos = -1;
    repeat (200) begin
      tick(1'b0, 2'd0);
      if (cur.nf) begin nf_cnt++; nf_h = int'(cur.h); nf_v = int'(cur.v); end
      if (cur.hs) begin
        if (first_pos < 0) first_pos = int'(cur.h);
        last_pos = int'(cur.h);
      end
    end
    check_val("nf_count_720", nf_cnt, 1);
    check_val("nf_h_720", nf_h, 1280);
    check_val("nf_v_720", nf_v, 720);
    check_val("hs_first_720", first_pos, 1390);
    check_val("hs_last_720", last_pos, 1429);
    jump(1645, 749);
    repeat (10) tick(1'b0, 2'd0);
    check_val("fc_after_frame", int'(cur.fc), 1);
    check_val("pos_after_frame", int'({cur.h, cur.v}), int'({12'd5, 11'd0}));
    run_table(2'd1);

    // 720p -> 1080p requested mid-frame, applied only at the wrap
    jump(100, 10);
    tick(1'b1, 2'd2);
    repeat (3) tick(1'b0, 2'd0);
    check_val("mode_held_before_wrap", int'(cur.mode), 1);
    jump(1646, 749);
    repeat (3) tick(1'b0, 2'd0);
    check_val("wrap_cycle_720", int'({cur.h, cur.v, cur.mode, cur.ack}), int'({12'd1649, 11'd749, 2'd1, 1'b0}));
    tick(1'b0, 2'd0);
    check_val("switch_to_1080", int'({cur.h, cur.v, cur.mode, cur.ack}), int'({12'd0, 11'd0, 2'd2, 1'b1}));
    tick(1'b0, 2'd0);
    check_val("ack_single_cycle", int'(cur.ack), 0);
    jump(2199, 1123);
    tick(1'b0, 2'd0);
    check_val("line_1124_1080", int'({cur.h, cur.v}), int'({12'd0, 11'd1124}));
    jump(2198, 1124);
    repeat (2) tick(1'b0, 2'd0);
    check_val("vtotal_1125", int'({cur.h, cur.v}), int'({12'd0, 11'd0}));
    run_table(2'd2);

    // Newer request overwrites older: request 0 then 2 -> stays 2, one ack
    jump(50, 20);
    tick(1'b1, 2'd0);
    repeat (2) tick(1'b0, 2'd0);
    tick(1'b1, 2'd2);
    jump(2190, 1124);
    run_count(20, acks);
    check_val("overwrite_acks", acks, 1);
    check_val("overwrite_mode", int'(cur.mode), 2);

    // Invalid request: error pulse, no ack, no mode change
    tick(1'b1, 2'd3);
    check_val("err_pulse", int'(cur.err), 1);
    tick(1'b0, 2'd0);
    check_val("err_clear", int'(cur.err), 0);
    jump(2190, 1124);
    run_count(20, acks);
    check_val("invalid_no_ack", acks, 0);
    check_val("invalid_mode_kept", int'(cur.mode), 2);
    // Invalid request must not disturb an already pending one
    tick(1'b1, 2'd0);
    tick(1'b1, 2'd3);
    check_val("err_pulse_pending", int'(cur.err), 1);
    jump(2190, 1124);
    run_count(20, acks);
    check_val("pending_survives_acks", acks, 1);
    check_val("pending_survives_mode", int'(cur.mode), 0);

    // 480p negative sync: hs low 656..751, vs low on lines 490..491
    jump(650, 100);
    first_pos = -1; last_pos = -1;
    repeat (110) begin
      tick(1'b0, 2'd0);
      if (!cur.hs) begin
        if (first_pos < 0) first_pos = int'(cur.h);
        last_pos = int'(cur.h);
      end
    end
    check_val("hs_low_first_480", first_pos, 656);
    check_val("hs_low_last_480", last_pos, 751);
    jump(795, 488);
    first_pos = -1; last_pos = -1;
    repeat (3200) begin
      tick(1'b0, 2'd0);
      if (!cur.vs) begin
        if (first_pos < 0) first_pos = int'(cur.v);
        last_pos = int'(cur.v);
      end
    end
    check_val("vs_low_first_480", first_pos, 490);
    check_val("vs_low_last_480", last_pos, 491);
    run_table(2'd0);

    // Reset mid-frame with a request pending discards everything
    tick(1'b1, 2'd2);
    repeat (5) tick(1'b0, 2'd0);
    assert_reset();
    check_val("mode_after_reset", int'(cur.mode), 1);
    jump(1640, 749);
    run_count(20, acks);
    check_val("reset_drops_pending_acks", acks, 0);
    check_val("reset_drops_pending_mode", int'(cur.mode), 1);

    // Request arriving on the wrap cycle is applied at that same wrap
    jump(1648, 749);
    tick(1'b0, 2'd0);
    check_val("at_wrap_720", int'({cur.h, cur.v}), int'({12'd1649, 11'd749}));
    tick(1'b1, 2'd0);
    check_val("req_on_wrap", int'({cur.h, cur.v, cur.mode, cur.ack}), int'({12'd0, 11'd0, 2'd0, 1'b1}));
    repeat (3) tick(1'b0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
